// File: rtl/n1_pkg.sv
// Shared definitions for the n1 sequencer: widths, FSM state codes,
// host command opcodes and a small state-classification helper.
package n1_pkg;

    localparam int PADDR_W = 5;
    localparam int INST_W  = 16;
    localparam int PC_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_FETCH   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_HALTED  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_STOP = 2'b11
    } cmd_op_t;

    // States in which non-STOP host commands are accepted.
    function automatic logic accepts_cmd(input state_t s);
        return (s == ST_IDLE) || (s == ST_LOAD_LO) || (s == ST_HALTED);
    endfunction

endpackage

// File: rtl/n1_load_asm.sv
// Program loader: pairs host bytes into 16-bit words, tracks the load
// address and issues a one-cycle registered program RAM write.
// Ports: clk, rst_n, ena; hi_stb/lo_stb/clr/data from the FSM;
//        pram_we/pram_waddr/pram_wdata program RAM write port.
module n1_load_asm
    import n1_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               hi_stb,
    input  logic               lo_stb,
    input  logic               clr,
    input  logic [7:0]         data,
    output logic               pram_we,
    output logic [PADDR_W-1:0] pram_waddr,
    output logic [INST_W-1:0]  pram_wdata
);

    logic [7:0]         hi_byte;
    logic [PADDR_W-1:0] ld_addr;
    logic               we_q;
    logic [PADDR_W-1:0] waddr_q;
    logic [INST_W-1:0]  wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte <= '0;
            ld_addr <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (ena) begin
            if (clr) begin
                hi_byte <= '0;
                ld_addr <= '0;
                we_q    <= 1'b0;
            end else begin
                we_q <= lo_stb;
                if (hi_stb) begin
                    hi_byte <= data;
                end
                if (lo_stb) begin
                    waddr_q <= ld_addr;
                    wdata_q <= {hi_byte, data};
                    // 5-bit counter: 31 wraps naturally to 0
                    ld_addr <= ld_addr + 1'b1;
                end
            end
        end
    end

    // A frozen block must never write the RAM.
    assign pram_we    = we_q & ena;
    assign pram_waddr = waddr_q;
    assign pram_wdata = wdata_q;

endmodule

// File: rtl/n1_seq_ctrl.sv
// n1 sequencer top: command FSM, program counter, fetch path and
// instruction handshake to execute; loader lives in n1_load_asm.
// Ports: host cmd_*, program RAM pram_*, execute inst_*/jmp_*/halt_req,
//        status pc and state.
module n1_seq_ctrl
    import n1_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [7:0]         cmd_data,
    output logic               cmd_ready,
    output logic               pram_we,
    output logic [PADDR_W-1:0] pram_waddr,
    output logic [INST_W-1:0]  pram_wdata,
    output logic [PADDR_W-1:0] pram_raddr,
    input  logic [INST_W-1:0]  pram_rdata,
    output logic               inst_valid,
    output logic [INST_W-1:0]  inst,
    input  logic               inst_ready,
    input  logic               jmp_valid,
    input  logic [PC_W-1:0]    jmp_target,
    input  logic               halt_req,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         state
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                run_q, run_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                iv_q, iv_d;
    logic                hi_stb, lo_stb, clr;

    cmd_op_t op;
    logic    is_stop;
    logic    take;
    logic    start;
    logic    ld_hi;
    logic    ld_lo;

    assign op        = cmd_op_t'(cmd_op);
    assign cmd_ready = accepts_cmd(state_q);
    assign is_stop   = cmd_valid && (op == OP_STOP);
    assign take      = cmd_valid && cmd_ready && !is_stop;
    assign start     = take && ((op == OP_RUN) || (op == OP_STEP));
    assign ld_hi     = take && (op == OP_LOAD) && (state_q == ST_IDLE);
    assign ld_lo     = take && (op == OP_LOAD) && (state_q == ST_LOAD_LO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            run_q   <= 1'b0;
            inst_q  <= '0;
            iv_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= run_d;
            inst_q  <= inst_d;
            iv_q    <= iv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        run_d   = run_q;
        inst_d  = inst_q;
        iv_d    = iv_q;
        hi_stb  = 1'b0;
        lo_stb  = 1'b0;
        clr     = 1'b0;
        // STOP overrides everything, including a same-edge handshake.
        if (is_stop) begin
            state_d = ST_IDLE;
            pc_d    = '0;
            iv_d    = 1'b0;
            clr     = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_LOAD_LO, ST_HALTED: begin
                    // LOAD in HALTED matches nothing and is dropped.
                    unique case (1'b1)
                        start: begin
                            run_d   = (op == OP_RUN);
                            state_d = ST_FETCH;
                        end
                        ld_hi: begin
                            hi_stb  = 1'b1;
                            state_d = ST_LOAD_LO;
                        end
                        ld_lo: begin
                            lo_stb  = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: ;
                    endcase
                end
                ST_FETCH: begin
                    state_d = ST_LATCH;
                end
                ST_LATCH: begin
                    inst_d  = pram_rdata;
                    iv_d    = 1'b1;
                    state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (inst_ready) begin
                        iv_d = 1'b0;
                        pc_d = jmp_valid ? jmp_target : pc_q + 1'b1;
                        if (halt_req || !run_q) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    n1_load_asm u_load (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .hi_stb     (hi_stb),
        .lo_stb     (lo_stb),
        .clr        (clr),
        .data       (cmd_data),
        .pram_we    (pram_we),
        .pram_waddr (pram_waddr),
        .pram_wdata (pram_wdata)
    );

    // Read address always tracks the pc; only FETCH relies on it.
    assign pram_raddr = pc_q[PADDR_W-1:0];
    assign inst_valid = iv_q;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign state      = state_q;

endmodule

// File: tb/tb_n1_seq_ctrl.sv
// Self-checking bench for n1_seq_ctrl with a behavioural program model.
// Drives at posedge+1, samples at posedge+1 after each edge.
module tb_n1_seq_ctrl;

    localparam logic [1:0] C_LD   = 2'b00;
    localparam logic [1:0] C_RUN  = 2'b01;
    localparam logic [1:0] C_STEP = 2'b10;
    localparam logic [1:0] C_STOP = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        pram_we;
    logic [4:0]  pram_waddr;
    logic [15:0] pram_wdata;
    logic [4:0]  pram_raddr;
    logic [15:0] pram_rdata;
    logic        inst_valid;
    logic [15:0] inst;
    logic        inst_ready;
    logic        jmp_valid;
    logic [7:0]  jmp_target;
    logic        halt_req;
    logic [7:0]  pc;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [32];
    logic [15:0] mdl_mem [32];
    int          mdl_ld = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pram_we) ram[pram_waddr] <= pram_wdata;
        pram_rdata <= ram[pram_raddr];
    end

    n1_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .pram_we(pram_we), .pram_waddr(pram_waddr),
        .pram_wdata(pram_wdata), .pram_raddr(pram_raddr),
        .pram_rdata(pram_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .halt_req(halt_req), .pc(pc), .state(state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic ld_word(input logic [15:0] w);
        cmd(C_LD, w[15:8]);
        cmd(C_LD, w[7:0]);
        mdl_mem[mdl_ld] = w;
        mdl_ld = (mdl_ld + 1) % 32;
    endtask

    task automatic do_stop();
        cmd(C_STOP, 8'h00);
        mdl_ld = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL rst_pc got %0d exp 0", pc); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_iv got %b exp 0", inst_valid); end
        checks++; if (inst !== 16'h0) begin errors++; $display("FAIL rst_inst got %h exp 0000", inst); end
        checks++; if (pram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", pram_we); end
        checks++; if (pram_waddr !== 5'd0 || pram_wdata !== 16'h0) begin errors++; $display("FAIL rst_wport got %0d/%h exp 0/0000", pram_waddr, pram_wdata); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
        rst_n = 1'b1;
        step();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_rel_state got %0d exp 0", state); end
    endtask

    task automatic test_load_basic();
        logic [15:0] w;
        cmd(C_LD, 8'h12);
        checks++; if (state !== 3'd1 || pram_we !== 1'b0) begin errors++; $display("FAIL ld_hi0 got st%0d we%b exp st1 we0", state, pram_we); end
        cmd(C_LD, 8'h34);
        checks++; if (pram_we !== 1'b1 || pram_waddr !== 5'd0 || pram_wdata !== 16'h1234) begin errors++; $display("FAIL ld_w0 got we%b %0d %h exp we1 0 1234", pram_we, pram_waddr, pram_wdata); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL ld_st0 got %0d exp 0", state); end
        cmd(C_LD, 8'hAB);
        checks++; if (state !== 3'd1 || pram_we !== 1'b0) begin errors++; $display("FAIL ld_hi1 got st%0d we%b exp st1 we0", state, pram_we); end
        cmd(C_LD, 8'hCD);
        checks++; if (pram_we !== 1'b1 || pram_waddr !== 5'd1 || pram_wdata !== 16'hABCD) begin errors++; $display("FAIL ld_w1 got we%b %0d %h exp we1 1 abcd", pram_we, pram_waddr, pram_wdata); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL ld_st1 got %0d exp 0", state); end
        step();
        checks++; if (pram_we !== 1'b0) begin errors++; $display("FAIL ld_pulse got %b exp 0", pram_we); end
        mdl_mem[0] = 16'h1234;
        mdl_mem[1] = 16'hABCD;
        mdl_ld = 2;
        w = 16'($urandom);
        ld_word(w);
        checks++; if (pram_waddr !== 5'd2 || pram_wdata !== w) begin errors++; $display("FAIL ld_addr2 got %0d %h exp 2 %h", pram_waddr, pram_wdata, w); end
    endtask

    task automatic test_load_wrap();
        logic [15:0] w;
        do_stop();
        for (int i = 0; i < 33; i++) begin
            w = 16'($urandom);
            cmd(C_LD, w[15:8]);
            checks++; if (pram_we !== 1'b0) begin errors++; $display("FAIL wrap_gap%0d got we%b exp 0", i, pram_we); end
            cmd(C_LD, w[7:0]);
            checks++; if (pram_we !== 1'b1 || pram_waddr !== 5'(i % 32) || pram_wdata !== w) begin errors++; $display("FAIL wrap_w%0d got we%b %0d %h exp 1 %0d %h", i, pram_we, pram_waddr, pram_wdata, i % 32, w); end
            mdl_mem[i % 32] = w;
        end
        mdl_ld = 1;
        step();
        checks++; if (pram_we !== 1'b0) begin errors++; $display("FAIL wrap_end got we%b exp 0", pram_we); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (ram[i] !== mdl_mem[i]) begin errors++; $display("FAIL wrap_ram%0d got %h exp %h", i, ram[i], mdl_mem[i]); end
        end
    endtask

    task automatic test_step();
        do_stop();
        ld_word(16'hA001);
        ld_word(16'hA002);
        ld_word(16'hA003);
        inst_ready = 1'b1;
        cmd(C_STEP, 8'h00);
        checks++; if (state !== 3'd2 || pram_raddr !== 5'd0) begin errors++; $display("FAIL step_fetch got st%0d ra%0d exp st2 ra0", state, pram_raddr); end
        step();
        checks++; if (state !== 3'd3 || inst_valid !== 1'b0) begin errors++; $display("FAIL step_latch got st%0d iv%b exp st3 iv0", state, inst_valid); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst !== 16'hA001 || state !== 3'd4) begin errors++; $display("FAIL step_t2 got iv%b %h st%0d exp iv1 a001 st4", inst_valid, inst, state); end
        step();
        checks++; if (state !== 3'd5 || pc !== 8'd1 || inst_valid !== 1'b0) begin errors++; $display("FAIL step_halt got st%0d pc%0d iv%b exp st5 pc1 iv0", state, pc, inst_valid); end
        cmd(C_STEP, 8'h00);
        checks++; if (pram_raddr !== 5'd1) begin errors++; $display("FAIL step2_ra got %0d exp 1", pram_raddr); end
        step();
        step();
        checks++; if (inst_valid !== 1'b1 || inst !== 16'hA002) begin errors++; $display("FAIL step2_inst got iv%b %h exp iv1 a002", inst_valid, inst); end
        step();
        checks++; if (state !== 3'd5 || pc !== 8'd2) begin errors++; $display("FAIL step2_halt got st%0d pc%0d exp st5 pc2", state, pc); end
    endtask

    task automatic test_run_halt();
        int n = 0;
        int k = 0;
        int last = 0;
        bit done = 0;
        do_stop();
        inst_ready = 1'b1;
        cmd(C_RUN, 8'h00);
        while (k < 30 && !done) begin
            step();
            k++;
            halt_req = 1'b0;
            if (n == 3) begin
                done = 1;
            end else if (inst_valid) begin
                checks++; if (inst !== mdl_mem[n]) begin errors++; $display("FAIL run_inst%0d got %h exp %h", n, inst, mdl_mem[n]); end
                if (n == 0) begin
                    checks++; if (k != 2) begin errors++; $display("FAIL run_lat got %0d exp 2", k); end
                end else begin
                    checks++; if (k - last != 3) begin errors++; $display("FAIL run_gap%0d got %0d exp 3", n, k - last); end
                end
                last = k;
                halt_req = (n == 2);
                n++;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL run_timeout got %0d insts exp 3", n); end
        checks++; if (state !== 3'd5 || pc !== 8'd3 || inst_valid !== 1'b0) begin errors++; $display("FAIL run_halt got st%0d pc%0d iv%b exp st5 pc3 iv0", state, pc, inst_valid); end
    endtask

    task automatic test_jump();
        do_stop();
        inst_ready = 1'b1;
        cmd(C_RUN, 8'h00);
        step();
        step();
        checks++; if (inst_valid !== 1'b1 || inst !== mdl_mem[0]) begin errors++; $display("FAIL jmp_i0 got iv%b %h exp iv1 %h", inst_valid, inst, mdl_mem[0]); end
        jmp_valid  = 1'b1;
        jmp_target = 8'h25;
        step();
        jmp_valid   = 1'b0;
        inst_ready  = 1'b0;
        checks++; if (pc !== 8'h25 || state !== 3'd2 || pram_raddr !== 5'd5) begin errors++; $display("FAIL jmp_pc got pc%h st%0d ra%0d exp 25 2 5", pc, state, pram_raddr); end
        step();
        step();
        checks++; if (inst_valid !== 1'b1 || inst !== mdl_mem[5]) begin errors++; $display("FAIL jmp_i5 got iv%b %h exp iv1 %h", inst_valid, inst, mdl_mem[5]); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (inst_valid !== 1'b1 || inst !== mdl_mem[5] || state !== 3'd4) begin errors++; $display("FAIL jmp_hold%0d got iv%b %h st%0d exp iv1 %h st4", i, inst_valid, inst, state, mdl_mem[5]); end
        end
        inst_ready = 1'b1;
        halt_req   = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (state !== 3'd5 || pc !== 8'h26) begin errors++; $display("FAIL jmp_end got st%0d pc%h exp st5 26", state, pc); end
    endtask

    task automatic test_stop();
        inst_ready = 1'b1;
        cmd(C_RUN, 8'h00);
        checks++; if (state !== 3'd2 || pram_raddr !== 5'd6) begin errors++; $display("FAIL stop_resume got st%0d ra%0d exp 2 6", state, pram_raddr); end
        cmd(C_LD, 8'h77);
        checks++; if (state !== 3'd3 || pram_we !== 1'b0) begin errors++; $display("FAIL stop_drop got st%0d we%b exp 3 0", state, pram_we); end
        do_stop();
        checks++; if (state !== 3'd0 || pc !== 8'd0 || inst_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL stop_latch got st%0d pc%0d iv%b rdy%b exp 0 0 0 1", state, pc, inst_valid, cmd_ready); end
        cmd(C_LD, 8'hEE);
        do_stop();
        checks++; if (state !== 3'd0 || pram_we !== 1'b0) begin errors++; $display("FAIL stop_ld got st%0d we%b exp 0 0", state, pram_we); end
        ld_word(16'h5AC3);
        checks++; if (pram_we !== 1'b1 || pram_waddr !== 5'd0 || pram_wdata !== 16'h5AC3) begin errors++; $display("FAIL stop_ld2 got we%b %0d %h exp 1 0 5ac3", pram_we, pram_waddr, pram_wdata); end
        cmd(C_RUN, 8'h00);
        step();
        step();
        do_stop();
        checks++; if (state !== 3'd0 || pc !== 8'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL stop_hs got st%0d pc%0d iv%b exp 0 0 0", state, pc, inst_valid); end
    endtask

    task automatic test_async_reset();
        do_stop();
        inst_ready = 1'b1;
        cmd(C_STEP, 8'h00);
        step();
        step();
        step();
        inst_ready = 1'b0;
        cmd(C_STEP, 8'h00);
        step();
        step();
        checks++; if (state !== 3'd4 || pc !== 8'd1) begin errors++; $display("FAIL arst_pre got st%0d pc%0d exp 4 1", state, pc); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || pc !== 8'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL arst got st%0d pc%0d iv%b exp 0 0 0", state, pc, inst_valid); end
        step();
        rst_n = 1'b1;
        mdl_ld = 0;
        step();
        checks++; if (state !== 3'd0 || inst !== 16'h0) begin errors++; $display("FAIL arst_rel got st%0d %h exp 0 0000", state, inst); end
    endtask

    task automatic test_ena();
        do_stop();
        inst_ready = 1'b1;
        cmd(C_RUN, 8'h00);
        for (int i = 0; i < 4; i++) step();
        checks++; if (state !== 3'd3 || pc !== 8'd1) begin errors++; $display("FAIL ena_pre got st%0d pc%0d exp 3 1", state, pc); end
        ena       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = C_STOP;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (state !== 3'd3 || pc !== 8'd1 || pram_we !== 1'b0) begin errors++; $display("FAIL ena_frz%0d got st%0d pc%0d we%b exp 3 1 0", i, state, pc, pram_we); end
        end
        cmd_valid = 1'b0;
        ena       = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b1 || inst !== mdl_mem[1] || state !== 3'd4) begin errors++; $display("FAIL ena_res got iv%b %h st%0d exp 1 %h 4", inst_valid, inst, state, mdl_mem[1]); end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        checks++; if (state !== 3'd5 || pc !== 8'd2) begin errors++; $display("FAIL ena_end got st%0d pc%0d exp 5 2", state, pc); end
    endtask

    task automatic test_random();
        int  mpc = 0;
        bit  run;
        int  want;
        int  cnt;
        int  k;
        bit  hs;
        do_stop();
        for (int i = 0; i < 32; i++) ld_word(16'($urandom));
        for (int b = 0; b < 10; b++) begin
            run  = 1'($urandom % 2);
            want = run ? int'($urandom_range(1, 6)) : 1;
            cnt  = 0;
            k    = 0;
            hs   = 0;
            inst_ready = 1'b0;
            cmd(run ? C_RUN : C_STEP, 8'h00);
            while (k < 200 && cnt < want) begin
                step();
                k++;
                if (hs) begin
                    hs = 0;
                    inst_ready = 1'b0;
                    jmp_valid  = 1'b0;
                    halt_req   = 1'b0;
                end
                if (cnt < want && inst_valid) begin
                    checks++; if (inst !== mdl_mem[mpc % 32] || pc !== 8'(mpc)) begin errors++; $display("FAIL rnd_b%0d_i%0d got %h pc%0d exp %h pc%0d", b, cnt, inst, pc, mdl_mem[mpc % 32], mpc); end
                    if ($urandom % 4 != 0) begin
                        hs = 1;
                        inst_ready = 1'b1;
                        jmp_valid  = ($urandom % 4 == 0);
                        jmp_target = 8'($urandom);
                        halt_req   = run ? (cnt == want - 1) : 1'($urandom % 2);
                        mpc = jmp_valid ? int'(jmp_target) : (mpc + 1) % 256;
                        cnt++;
                    end
                end
            end
            step();
            inst_ready = 1'b0;
            jmp_valid  = 1'b0;
            halt_req   = 1'b0;
            checks++; if (cnt != want || state !== 3'd5 || pc !== 8'(mpc)) begin errors++; $display("FAIL rnd_end%0d got n%0d st%0d pc%0d exp n%0d st5 pc%0d", b, cnt, state, pc, want, mpc); end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_data   = 8'h00;
        inst_ready = 1'b0;
        jmp_valid  = 1'b0;
        jmp_target = 8'h00;
        halt_req   = 1'b0;
        test_reset();
        test_load_basic();
        test_load_wrap();
        test_step();
        test_run_halt();
        test_jump();
        test_stop();
        test_async_reset();
        test_ena();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
